// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad input path: key map, FSM states, scan result codes.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_RELEASING = 2'd3
  } kp_state_t;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } scan_res_t;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'h0;
      4'hD: code = 4'hF;
      4'hE: code = 4'hE;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Active-bit count saturated at 2, which already means "more than one key".
  function automatic logic [1:0] bit_count_sat(input logic [3:0] bits);
    logic [2:0] sum;
    sum = {2'b00, bits[0]} + {2'b00, bits[1]} + {2'b00, bits[2]} + {2'b00, bits[3]};
    return (sum >= 3'd2) ? 2'd2 : sum[1:0];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous level signals.
module sync_2ff #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Double-register the asynchronous input into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, row sampling, ghost rejection,
// press/release debounce and hex encoding of the accepted key.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_val,
  output logic       key_held,
  output logic       key_pulse
);

  localparam int               DIV_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
  localparam int               CNT_W      = $clog2(DEBOUNCE_SCANS + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [3:0]       row_sync_s;
  logic [DIV_W-1:0] div_r;
  logic [1:0]       col_r;
  logic [3:0]       col_out_r;
  logic [1:0]       acc_cnt_r;
  logic [3:0]       acc_code_r;

  logic             sample_s;
  logic             eval_s;
  logic [3:0]       col_active_s;
  logic [1:0]       col_cnt_s;
  logic [1:0]       row_idx_s;
  logic [1:0]       base_cnt_s;
  logic [3:0]       base_code_s;
  logic [2:0]       sum_cnt_s;
  logic [1:0]       total_cnt_s;
  logic [3:0]       total_code_s;
  scan_res_t        res_s;

  kp_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       cand_r;
  logic [3:0]       key_val_r;
  logic             key_held_r;
  logic             key_pulse_r;

  // Rows idle high, so the synchronizer resets to "no row active".
  sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_in),
    .q     (row_sync_s)
  );

  // Fold the current column's rows into the running scan result.
  always_comb begin
    sample_s     = (div_r == DIV_LAST);
    eval_s       = sample_s && (col_r == 2'd3);
    col_active_s = ~row_sync_s;
    col_cnt_s    = bit_count_sat(col_active_s);
    case (col_active_s)
      4'b0010: row_idx_s = 2'd1;
      4'b0100: row_idx_s = 2'd2;
      4'b1000: row_idx_s = 2'd3;
      default: row_idx_s = 2'd0;
    endcase
    if (col_r == 2'd0) begin
      base_cnt_s  = 2'd0;
      base_code_s = 4'h0;
    end else begin
      base_cnt_s  = acc_cnt_r;
      base_code_s = acc_code_r;
    end
    sum_cnt_s = {1'b0, base_cnt_s} + {1'b0, col_cnt_s};
    if (sum_cnt_s >= 3'd2) begin
      total_cnt_s = 2'd2;
    end else begin
      total_cnt_s = sum_cnt_s[1:0];
    end
    if (col_cnt_s == 2'd1) begin
      total_code_s = key_code(row_idx_s, col_r);
    end else begin
      total_code_s = base_code_s;
    end
    case (total_cnt_s)
      2'd0:    res_s = RES_NONE;
      2'd1:    res_s = RES_SINGLE;
      default: res_s = RES_MULTI;
    endcase
  end

  // Column divider, column drive and per-scan accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r      <= {DIV_W{1'b0}};
      col_r      <= 2'd0;
      col_out_r  <= 4'b1110;
      acc_cnt_r  <= 2'd0;
      acc_code_r <= 4'h0;
    end else if (sample_s) begin
      div_r      <= {DIV_W{1'b0}};
      col_r      <= col_r + 2'd1;
      col_out_r  <= ~(4'b0001 << (col_r + 2'd1));
      acc_cnt_r  <= total_cnt_s;
      acc_code_r <= total_code_s;
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  // Debounce FSM, stepped once per completed scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      cand_r      <= 4'h0;
      key_val_r   <= 4'h0;
      key_held_r  <= 1'b0;
      key_pulse_r <= 1'b0;
    end else begin
      key_pulse_r <= 1'b0;
      if (eval_s) begin
        case (state_r)
          ST_IDLE: begin
            if (res_s == RES_SINGLE) begin
              if (DEBOUNCE_SCANS == 1) begin
                state_r     <= ST_PRESSED;
                cnt_r       <= {CNT_W{1'b0}};
                key_val_r   <= total_code_s;
                key_held_r  <= 1'b1;
                key_pulse_r <= 1'b1;
              end else begin
                state_r <= ST_ARMING;
                cand_r  <= total_code_s;
                cnt_r   <= CNT_ONE;
              end
            end
          end
          ST_ARMING: begin
            if (res_s == RES_SINGLE && total_code_s == cand_r) begin
              if (cnt_r + CNT_ONE >= CNT_TARGET) begin
                state_r     <= ST_PRESSED;
                cnt_r       <= {CNT_W{1'b0}};
                key_val_r   <= cand_r;
                key_held_r  <= 1'b1;
                key_pulse_r <= 1'b1;
              end else begin
                cnt_r <= cnt_r + CNT_ONE;
              end
            end else if (res_s == RES_SINGLE) begin
              cand_r <= total_code_s;
              cnt_r  <= CNT_ONE;
            end else begin
              state_r <= ST_IDLE;
              cnt_r   <= {CNT_W{1'b0}};
            end
          end
          ST_PRESSED: begin
            if (!(res_s == RES_SINGLE && total_code_s == key_val_r)) begin
              if (DEBOUNCE_SCANS == 1) begin
                state_r    <= ST_IDLE;
                cnt_r      <= {CNT_W{1'b0}};
                key_held_r <= 1'b0;
              end else begin
                state_r <= ST_RELEASING;
                cnt_r   <= CNT_ONE;
              end
            end
          end
          ST_RELEASING: begin
            if (res_s == RES_SINGLE && total_code_s == key_val_r) begin
              state_r <= ST_PRESSED;
              cnt_r   <= {CNT_W{1'b0}};
            end else if (cnt_r + CNT_ONE >= CNT_TARGET) begin
              state_r    <= ST_IDLE;
              cnt_r      <= {CNT_W{1'b0}};
              key_held_r <= 1'b0;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            key_held_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign col_out   = col_out_r;
  assign key_val   = key_val_r;
  assign key_held  = key_held_r;
  assign key_pulse = key_pulse_r;

endmodule
